uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 93 +++++++++
 tb/tb_uart_rx_fifo.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular receive buffer behind the UART receiver.
// Stores bytes on the receiver's done tick and presents them first-word-fall-through.
// Reports occupancy and a sticky overrun flag.
module uart_rx_fifo #(
    parameter int unsigned DBIT   = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DBIT-1:0]   w_data,
    input  logic              rd,
    output logic [DBIT-1:0]   r_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

    logic [DBIT-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overrun;

    logic              w_empty;
    logic              w_full;
    logic              w_rd_ok;
    logic              w_wr_ok;
    logic              w_drop;
    logic [ADDR_W:0]   w_count_next;
    logic              w_overrun_next;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FullCount);

    // Accept decisions; a pop on a full buffer frees the slot the write needs.
    always_comb begin
        w_rd_ok        = rd && !w_empty;
        w_wr_ok        = wr && (!w_full || w_rd_ok);
        w_drop         = wr && w_full && !w_rd_ok;
        w_count_next   = r_count;
        if (w_wr_ok && !w_rd_ok) begin
            w_count_next = r_count + 1'b1;
        end else if (w_rd_ok && !w_wr_ok) begin
            w_count_next = r_count - 1'b1;
        end
        // A drop in the same cycle as a clear keeps the flag set.
        w_overrun_next = r_overrun;
        if (w_drop) begin
            w_overrun_next = 1'b1;
        end else if (clr_overrun) begin
            w_overrun_next = 1'b0;
        end
    end

    // Pointer, occupancy and overrun state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count   <= w_count_next;
            r_overrun <= w_overrun_next;
        end
    end

    // Storage array; contents are never reset, only pointers are.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_ok) begin
            r_mem[r_wptr] <= w_data;
        end
    end

    assign r_data  = r_mem[r_rptr];
    assign empty   = w_empty;
    assign full    = w_full;
    assign count   = r_count;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       rd = 1'b0;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       clr_overrun = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [7:0] q[$];
    bit         m_ov = 1'b0;
    int         max_cnt;

    uart_rx_fifo #(.DBIT(8), .ADDR_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr          (wr),
        .w_data      (w_data),
        .rd          (rd),
        .r_data      (r_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ".overrun"}, 32'(overrun), 32'(m_ov));
        if (q.size() != 0) chk({tag, ".r_data"}, 32'(r_data), 32'(q[0]));
    endtask

    // One clock: drive inputs, advance past the edge, update the model, compare.
    task automatic cycle(input string tag, input bit iwr, input logic [7:0] d,
                         input bit ird, input bit iclr);
        int  pre;
        bit  rd_ok;
        bit  wr_ok;
        wr = iwr; w_data = d; rd = ird; clr_overrun = iclr;
        pre   = q.size();
        rd_ok = ird && pre > 0;
        wr_ok = iwr && (pre < DEPTH || rd_ok);
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; clr_overrun = 1'b0;
        if (rd_ok) void'(q.pop_front());
        if (wr_ok) q.push_back(d);
        if (iwr && !wr_ok) m_ov = 1'b1;
        else if (iclr) m_ov = 1'b0;
        if (q.size() > max_cnt) max_cnt = q.size();
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        wr = 1'b1; w_data = 8'hEE; rd = 1'b1; clr_overrun = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0; wr = 1'b0; rd = 1'b0;
        q.delete();
        m_ov = 1'b0;
        check_state(tag);
    endtask

    initial begin
        @(posedge clk);
        do_reset("reset");

        // Three writes, then three pops.
        cycle("w41", 1'b1, 8'h41, 1'b0, 1'b0);
        cycle("w42", 1'b1, 8'h42, 1'b0, 1'b0);
        cycle("w43", 1'b1, 8'h43, 1'b0, 1'b0);
        chk("three.count", 32'(count), 32'd3);
        chk("three.head", 32'(r_data), 32'h41);
        for (int i = 0; i < 3; i++) cycle("pop3", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("three.empty", 32'(empty), 32'd1);

        // Fill, drop one byte, drain.
        for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill.full", 32'(full), 32'd1);
        cycle("drop", 1'b1, 8'hAA, 1'b0, 1'b0);
        chk("drop.overrun", 32'(overrun), 32'd1);
        chk("drop.count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("clr", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr.overrun", 32'(overrun), 32'd0);

        // Full with simultaneous write and pop.
        for (int i = 0; i < 16; i++) cycle("fill2", 1'b1, 8'(i), 1'b0, 1'b0);
        cycle("fullwr", 1'b1, 8'h55, 1'b1, 1'b0);
        chk("fullwr.overrun", 32'(overrun), 32'd0);
        chk("fullwr.head", 32'(r_data), 32'h01);
        for (int i = 0; i < 16; i++) cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain2.empty", 32'(empty), 32'd1);

        // Pop on empty, then write+pop on empty.
        cycle("rdempty", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("wrrdempty", 1'b1, 8'h7E, 1'b1, 1'b0);
        chk("wrrdempty.data", 32'(r_data), 32'h7E);
        cycle("pop7e", 1'b0, 8'h00, 1'b1, 1'b0);

        // Pointer wrap with interleaved write/pop pairs.
        max_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle("wrapw", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
            cycle("wrapr", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("wrap.maxcount", 32'(max_cnt), 32'd1);

        // Same-cycle clear and drop keeps overrun set.
        for (int i = 0; i < 16; i++) cycle("fill3", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle("clrdrop", 1'b1, 8'h99, 1'b0, 1'b1);
        chk("clrdrop.overrun", 32'(overrun), 32'd1);

        // Reset mid-stream with five entries.
        do_reset("reset2");
        for (int i = 0; i < 5; i++) cycle("five", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        do_reset("reset5");
        chk("reset5.count", 32'(count), 32'd0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            cycle("rand", ($urandom_range(99) < 55), 8'($urandom), ($urandom_range(99) < 45),
                  ($urandom_range(99) < 5));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
